// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the multi-channel ADC capture path.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int DSIZE_W = 32;
  localparam int DECIM_W = 8;

  // Channel-index width, never below one bit so single-channel builds still have a tuser wire
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_mc_if.sv
// AXI-Stream link carrying one channel sample per beat, channel index in tuser.
interface adc_capture_mc_if #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 4
);
  import adc_capture_pkg::*;

  localparam int UW = ch_idx_w(NUM_CH);

  logic                  tvalid;
  logic                  tready;
  logic [SAMPLE_W-1:0]   tdata;
  logic [SAMPLE_W/8-1:0] tkeep;
  logic [UW-1:0]         tuser;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);

endinterface

// File: rtl/adc_capture_fifo.sv
// Synchronous snapshot FIFO with registered read data and count-derived full/empty flags.
module adc_capture_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_do, rd_do;

  // Flags come from the registered count, so a write while full is refused even if a read happens too
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_do   = wr_en && !full;
  assign rd_do   = rd_en && !empty;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr_q] <= wr_data;
    if (rd_do) rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_do) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_do && !rd_do)      cnt_q <= cnt_q + 1'b1;
      else if (rd_do && !wr_do) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC frame capture: snapshot FIFO feeding a channel serialiser on AXI-Stream.
// Optional decimation is built when ADC_CAPTURE_DECIM_EN is defined.
module adc_capture_mc
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       adc_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  input  logic                       cr_start,
  input  logic                       cr_test,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [DSIZE_W-1:0]         dsize,
`ifdef ADC_CAPTURE_DECIM_EN
  input  logic [DECIM_W-1:0]         decim,
`endif
  output logic                       sr_busy,
  output logic                       sr_pc,
  output logic                       sr_ovf,
  adc_capture_mc_if.master           m_axis
);
  localparam int CW = ch_idx_w(NUM_CH);
  localparam int FW = NUM_CH * SAMPLE_W;

  state_t              state_q;
  logic [DSIZE_W-1:0]  dsize_q, cnt_q, cnt_d, pop_cnt_q;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [SAMPLE_W-1:0] ramp_q;
  logic                ovf_q, snap_vld_q;
  logic [CW-1:0]       ch_q;
  logic                start_ok, cand, keep, fifo_wr, drop, fifo_rd;
  logic                fifo_full, fifo_empty, hs, last_ch, tlast, last_hs;
  logic [FW-1:0]       wr_data, rd_data;

  function automatic logic [CW-1:0] first_ch(input logic [NUM_CH-1:0] m);
    first_ch = '0;
    for (int k = NUM_CH-1; k >= 0; k--) if (m[k]) first_ch = CW'(k);
  endfunction

  function automatic logic [CW-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [CW-1:0] cur);
    next_ch = cur;
    for (int k = NUM_CH-1; k >= 0; k--) if (m[k] && (k > int'(cur))) next_ch = CW'(k);
  endfunction

  function automatic logic is_last(input logic [NUM_CH-1:0] m, input logic [CW-1:0] cur);
    is_last = 1'b1;
    for (int k = 0; k < NUM_CH; k++) if (m[k] && (k > int'(cur))) is_last = 1'b0;
  endfunction

  assign start_ok = (state_q == IDLE) && cr_start && (dsize != '0) && (ch_en != '0);
  assign cand     = (state_q == CAPTURE) && adc_valid;
  assign cnt_d    = cnt_q + 1'b1;

`ifdef ADC_CAPTURE_DECIM_EN
  logic [DECIM_W-1:0] decim_cnt_q;
  assign keep = cand && (decim_cnt_q == '0);

  always_ff @(posedge ACLK) begin
    if (ARESET)        decim_cnt_q <= '0;
    else if (start_ok) decim_cnt_q <= '0;
    else if (cand)     decim_cnt_q <= (decim_cnt_q == decim) ? '0 : decim_cnt_q + 1'b1;
  end
`else
  assign keep = cand;
`endif

  assign fifo_wr = keep && !fifo_full;
  assign drop    = keep && fifo_full;

  always_comb begin
    wr_data = adc_data;
    if (cr_test)
      for (int k = 0; k < NUM_CH; k++) wr_data[k*SAMPLE_W +: SAMPLE_W] = ramp_q + SAMPLE_W'(k);
  end

  adc_capture_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (fifo_wr),
    .wr_data (wr_data),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (rd_data),
    .empty   (fifo_empty)
  );

  // Serialiser: refill in the same cycle the last channel leaves, so back-to-back snapshots stream gap-free
  assign hs      = snap_vld_q && m_axis.tready;
  assign last_ch = is_last(ch_en_q, ch_q);
  assign tlast   = snap_vld_q && last_ch && (pop_cnt_q == dsize_q);
  assign last_hs = hs && tlast;
  assign fifo_rd = (state_q != IDLE) && !fifo_empty && (!snap_vld_q || (hs && last_ch));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      dsize_q    <= '0;
      ch_en_q    <= '0;
      cnt_q      <= '0;
      pop_cnt_q  <= '0;
      ramp_q     <= '0;
      ovf_q      <= 1'b0;
      ch_q       <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          state_q   <= CAPTURE;
          dsize_q   <= dsize;
          ch_en_q   <= ch_en;
          cnt_q     <= '0;
          pop_cnt_q <= '0;
          ramp_q    <= '0;
          ovf_q     <= 1'b0;
          ch_q      <= first_ch(ch_en);
        end
        CAPTURE: if (fifo_wr && (cnt_d == dsize_q)) state_q <= DRAIN;
        DRAIN:   if (last_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (fifo_wr) begin
        cnt_q  <= cnt_d;
        ramp_q <= ramp_q + 1'b1;
      end
      if (drop) ovf_q <= 1'b1;

      if (fifo_rd) begin
        snap_vld_q <= 1'b1;
        pop_cnt_q  <= pop_cnt_q + 1'b1;
      end else if (hs && last_ch) begin
        snap_vld_q <= 1'b0;
      end
      if (hs) ch_q <= last_ch ? first_ch(ch_en_q) : next_ch(ch_en_q, ch_q);
    end
  end

  assign sr_busy = (state_q != IDLE);
  assign sr_pc   = last_hs;
  assign sr_ovf  = ovf_q;

  assign m_axis.tvalid = snap_vld_q;
  assign m_axis.tdata  = snap_vld_q ? rd_data[int'(ch_q)*SAMPLE_W +: SAMPLE_W] : '0;
  assign m_axis.tkeep  = snap_vld_q ? '1 : '0;
  assign m_axis.tuser  = snap_vld_q ? ch_q : '0;
  assign m_axis.tlast  = tlast;

endmodule

// File: tb/tb_adc_capture_mc.sv
// Bench for adc_capture_mc: frame tables, overflow stall, random backpressure vs model, reset, decimation.
module tb_adc_capture_mc;
  localparam int NC = 4;
  localparam int SW = 16;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  u;
    logic        l;
  } beat_t;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] ds;
    logic        test;
    logic [63:0] data;
    int          first;
    int          n;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ARESET, adc_valid, cr_start_a, cr_start_b, cr_test;
  logic [63:0] adc_data;
  logic [3:0]  ch_en;
  logic [31:0] dsize;
`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0]  decim;
`endif
  logic busy_a, pc_a, ovf_a, busy_b, pc_b, ovf_b;

  adc_capture_mc_if #(.SAMPLE_W(SW), .NUM_CH(NC)) ifa ();
  adc_capture_mc_if #(.SAMPLE_W(SW), .NUM_CH(NC)) ifb ();

  adc_capture_mc #(.NUM_CH(NC), .SAMPLE_W(SW), .FIFO_DEPTH(512)) dut_a (
    .ACLK(clk), .ARESET(ARESET), .adc_valid(adc_valid), .adc_data(adc_data),
    .cr_start(cr_start_a), .cr_test(cr_test), .ch_en(ch_en), .dsize(dsize),
`ifdef ADC_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .sr_busy(busy_a), .sr_pc(pc_a), .sr_ovf(ovf_a), .m_axis(ifa)
  );

  adc_capture_mc #(.NUM_CH(NC), .SAMPLE_W(SW), .FIFO_DEPTH(4)) dut_b (
    .ACLK(clk), .ARESET(ARESET), .adc_valid(adc_valid), .adc_data(adc_data),
    .cr_start(cr_start_b), .cr_test(cr_test), .ch_en(ch_en), .dsize(dsize),
`ifdef ADC_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .sr_busy(busy_b), .sr_pc(pc_b), .sr_ovf(ovf_b), .m_axis(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  beat_t got_a[$], got_b[$], exp_q[$];
  int viol_a = 0, viol_b = 0, pcs_a = 0, pcs_b = 0;
  logic  stall_a = 1'b0, stall_b = 1'b0;
  beat_t prev_a, prev_b;

  // Observe at the falling edge: inputs change only just after the rising edge
  always @(negedge clk) begin
    beat_t b;
    if (ARESET) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      b.d = ifa.tdata; b.u = ifa.tuser; b.l = ifa.tlast;
      if (stall_a && (!ifa.tvalid || b != prev_a)) viol_a++;
      if (ifa.tvalid && ifa.tready) got_a.push_back(b);
      if (ifa.tvalid && ifa.tkeep != 2'b11) viol_a++;
      if (pc_a) pcs_a++;
      stall_a = ifa.tvalid && !ifa.tready;
      prev_a  = b;
      b.d = ifb.tdata; b.u = ifb.tuser; b.l = ifb.tlast;
      if (stall_b && (!ifb.tvalid || b != prev_b)) viol_b++;
      if (ifb.tvalid && ifb.tready) got_b.push_back(b);
      if (ifb.tvalid && ifb.tkeep != 2'b11) viol_b++;
      if (pc_b) pcs_b++;
      stall_b = ifb.tvalid && !ifb.tready;
      prev_b  = b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [3:0] en, input logic [31:0] ds);
    ch_en = en; dsize = ds; cr_start_a = 1'b1;
    tick();
    cr_start_a = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    adc_data = d; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int max_cyc);
    for (int i = 0; i < max_cyc && busy_a; i++) tick();
    check("idle_timeout_a", busy_a, 0);
  endtask

  task automatic compare_a(input string name);
    check({name, "_nbeats"}, got_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_a.size())
        check(name, {got_a[i].d, got_a[i].u, got_a[i].l}, {exp_q[i].d, exp_q[i].u, exp_q[i].l});
  endtask

  frame_t frames[2];
  beat_t  exp_tab[16];

  initial begin
    int ramp, mcnt, nl;
    logic [3:0]  en;
    logic [63:0] d;
    logic        v, t;

    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 4; k++) exp_tab[s*4+k] = '{d: 16'(s+k), u: 2'(k), l: (s == 2 && k == 3)};
    exp_tab[12] = '{d: 16'hAAAA, u: 2'd0, l: 1'b0};
    exp_tab[13] = '{d: 16'h5555, u: 2'd2, l: 1'b0};
    exp_tab[14] = '{d: 16'hAAAA, u: 2'd0, l: 1'b0};
    exp_tab[15] = '{d: 16'h5555, u: 2'd2, l: 1'b1};
    frames[0] = '{en: 4'b1111, ds: 32'd3, test: 1'b1, data: 64'h0, first: 0, n: 12};
    frames[1] = '{en: 4'b0101, ds: 32'd2, test: 1'b0, data: 64'h3333_5555_1111_AAAA, first: 12, n: 4};

    ARESET = 1'b1; adc_valid = 1'b0; adc_data = '0; cr_start_a = 1'b0; cr_start_b = 1'b0;
    cr_test = 1'b0; ch_en = '0; dsize = '0; ifa.tready = 1'b1; ifb.tready = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
    decim = 8'd0;
`endif
    repeat (3) tick();
    ARESET = 1'b0;
    tick();
    check("rst_tvalid", ifa.tvalid, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_outs", {pc_a, ifa.tlast, ifa.tdata, ifa.tuser}, 0);

    // Table-driven frames
    foreach (frames[f]) begin
      got_a.delete(); exp_q.delete(); pcs_a = 0;
      cr_test = frames[f].test;
      start_a(frames[f].en, frames[f].ds);
      for (int s = 0; s < int'(frames[f].ds); s++) push(frames[f].data);
      wait_idle_a(200);
      for (int i = 0; i < frames[f].n; i++) exp_q.push_back(exp_tab[frames[f].first + i]);
      compare_a($sformatf("frame%0d", f));
      check("frame_pc", pcs_a, 1);
    end

    // Overflow on the 4-deep instance while the stream is stalled
    got_b.delete(); pcs_b = 0;
    cr_test = 1'b1; ch_en = 4'b1001; dsize = 32'd8; cr_start_b = 1'b1;
    tick();
    cr_start_b = 1'b0; adc_valid = 1'b1;
    repeat (8) tick();
    check("ovf_set", ovf_b, 1);
    ifb.tready = 1'b1;
    for (int i = 0; i < 300 && busy_b; i++) tick();
    adc_valid = 1'b0;
    check("ovf_idle", busy_b, 0);
    check("ovf_nbeats", got_b.size(), 16);
    nl = 0;
    foreach (got_b[i]) if (got_b[i].l) nl++;
    check("ovf_ntlast", nl, 1);
    for (int s = 0; s < 8; s++)
      for (int j = 0; j < 2; j++)
        if (s*2+j < got_b.size())
          check("ovf_beat", {got_b[s*2+j].d, got_b[s*2+j].u, got_b[s*2+j].l},
                {16'(s + 3*j), 2'(3*j), 1'(s == 7 && j == 1)});
    check("ovf_sticky", ovf_b, 1);
    check("ovf_pc", pcs_b, 1);
    check("ovf_viol", viol_b, 0);

    // Random data, test mode and backpressure against a frame-level model
    got_a.delete(); exp_q.delete(); pcs_a = 0; viol_a = 0;
    en = 4'($urandom_range(1, 15));
    start_a(en, 32'd100);
    ramp = 0; mcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      v = 1'($urandom); t = 1'($urandom); d = {$urandom, $urandom};
      adc_valid = v; cr_test = t; adc_data = d; ifa.tready = 1'($urandom);
      if (v && mcnt < 100) begin
        for (int k = 0; k < 4; k++)
          if (en[k]) exp_q.push_back('{d: t ? 16'(ramp + k) : d[k*16 +: 16], u: 2'(k), l: 1'b0});
        mcnt++; ramp++;
        if (mcnt == 100) exp_q[exp_q.size()-1].l = 1'b1;
      end
      tick();
      if (mcnt == 100 && !busy_a) break;
    end
    adc_valid = 1'b0; ifa.tready = 1'b1;
    check("rand_idle", busy_a, 0);
    compare_a("rand");
    check("rand_pc", pcs_a, 1);
    check("rand_stall_viol", viol_a, 0);

    // Reset while draining, then a fresh one-snapshot frame
    cr_test = 1'b0; ifa.tready = 1'b0;
    start_a(4'b1111, 32'd2);
    push(64'hDEAD_BEEF_CAFE_F00D);
    push(64'h1234_5678_9ABC_DEF0);
    repeat (4) tick();
    check("drain_tvalid", ifa.tvalid, 1);
    ARESET = 1'b1;
    tick();
    check("mid_rst_outs", {ifa.tvalid, ifa.tlast, ifa.tdata, ifa.tuser, pc_a, busy_a, ovf_a}, 0);
    ARESET = 1'b0; ifa.tready = 1'b1;
    got_a.delete(); exp_q.delete();
    start_a(4'b1111, 32'd1);
    cr_test = 1'b1; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    check("lat_n1", ifa.tvalid, 0);
    tick();
    check("lat_n2", ifa.tvalid, 1);
    wait_idle_a(50);
    for (int k = 0; k < 4; k++) exp_q.push_back('{d: 16'(k), u: 2'(k), l: (k == 3)});
    compare_a("post_rst");

    // Starts that must be refused
    start_a(4'b0000, 32'd5);
    check("start_en0", busy_a, 0);
    start_a(4'b0011, 32'd0);
    check("start_ds0", busy_a, 0);

`ifdef ADC_CAPTURE_DECIM_EN
    got_a.delete(); exp_q.delete();
    decim = 8'd2; cr_test = 1'b1;
    start_a(4'b0001, 32'd2);
    repeat (6) push(64'h0);
    wait_idle_a(50);
    exp_q.push_back('{d: 16'd0, u: 2'd0, l: 1'b0});
    exp_q.push_back('{d: 16'd1, u: 2'd0, l: 1'b1});
    compare_a("decim");
    check("decim_ovf", ovf_a, 0);
    decim = 8'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
